// File: rtl/oam_dma_if.sv
// Bus bundle between the OAM DMA engine and the rest of the system: snooped CPU
// write port, CPU run-enable, and the DMA-driven system bus.
interface oam_dma_if;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_out;
  logic        cpu_we;
  logic        cpu_locked;
  logic        dma_active;
  logic [15:0] bus_address;
  logic [7:0]  bus_in;
  logic [7:0]  bus_out;
  logic        bus_rd;
  logic        bus_we;

  // DMA engine side
  modport master (
    input  cpu_address, cpu_out, cpu_we, bus_in,
    output cpu_locked, dma_active, bus_address, bus_out, bus_rd, bus_we
  );

  // System / CPU / memory side
  modport slave (
    output cpu_address, cpu_out, cpu_we, bus_in,
    input  cpu_locked, dma_active, bus_address, bus_out, bus_rd, bus_we
  );
endinterface

// File: rtl/oam_dma.sv
// Sprite-memory DMA: a CPU write to $4014 halts the CPU and copies 256 bytes from
// page {cpu_out,00..FF} to $2004, with reads aligned to even CPU cycles.
module oam_dma (
  input  logic      clock,
  input  logic      reset,
  input  logic      ce,
  oam_dma_if.master dma_io
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic       par_q, par_d;
  logic       trig_s;
  logic       dma_active_s;

  assign trig_s = dma_io.cpu_we && (dma_io.cpu_address == 16'h4014);

  // State register; every _d already holds its _q value when ce is low.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      data_q  <= 8'h00;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      par_q   <= par_d;
    end
  end

  // Next-state logic; par runs freely so reads always land on par=0.
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    data_d  = data_q;
    par_d   = par_q ^ ce;
    if (ce) begin
      case (state_q)
        ST_IDLE: begin
          if (trig_s) begin
            page_d  = dma_io.cpu_out;
            idx_d   = 8'h00;
            state_d = ST_HALT;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HALT: begin
          if (par_q) begin
            state_d = ST_READ;
          end else begin
            state_d = ST_ALIGN;
          end
        end
        ST_ALIGN: state_d = ST_READ;
        ST_READ: begin
          data_d  = dma_io.bus_in;
          state_d = ST_WRITE;
        end
        ST_WRITE: begin
          idx_d = idx_q + 8'd1;
          if (idx_q == 8'hFF) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_READ;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Bus outputs decoded purely from registered state.
  always_comb begin
    dma_active_s       = (state_q != ST_IDLE);
    dma_io.bus_rd      = 1'b0;
    dma_io.bus_we      = 1'b0;
    dma_io.bus_address = 16'h0000;
    dma_io.bus_out     = data_q;
    case (state_q)
      ST_READ: begin
        dma_io.bus_rd      = 1'b1;
        dma_io.bus_address = {page_q, idx_q};
      end
      ST_WRITE: begin
        dma_io.bus_we      = 1'b1;
        dma_io.bus_address = 16'h2004;
      end
      default: begin
        dma_io.bus_rd      = 1'b0;
        dma_io.bus_we      = 1'b0;
        dma_io.bus_address = 16'h0000;
      end
    endcase
  end

  assign dma_io.dma_active = dma_active_s;
  // The CPU only runs on enabled cycles the DMA does not own.
  assign dma_io.cpu_locked = ce & ~dma_active_s;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: reset, address decode, aligned/unaligned transfers,
// ce gating at 1-in-3 and 1-in-12, and reset abort mid-transfer.
module tb_oam_dma;
  logic clock;
  logic reset;
  logic ce;
  int   checks;
  int   errors;
  logic tb_par;

  oam_dma_if ifc ();

  oam_dma u_dut (
    .clock (clock),
    .reset (reset),
    .ce    (ce),
    .dma_io(ifc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model RAM: page $02 holds i ^ 8'h5A, everything else reads 8'hEE.
  always_comb begin
    if (ifc.bus_address[15:8] == 8'h02) ifc.bus_in = ifc.bus_address[7:0] ^ 8'h5A;
    else ifc.bus_in = 8'hEE;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; tb_par models the free-running parity bit.
  task automatic tick();
    logic was_ce;
    was_ce = ce;
    @(posedge clock);
    #1;
    if (reset) tb_par = 1'b0;
    else if (was_ce) tb_par = ~tb_par;
  endtask

  task automatic run_xfer(input int period, input logic want_par, input int abort_at, input logic inject);
    int k, nce, nwr, nrd, dummies, gate_err, addr_err, clocks, wr_after;
    logic [7:0]  wdata [256];
    logic [25:0] snap;
    logic        was_ce;
    ifc.cpu_we = 1'b0;
    ce = 1'b1;
    // HALT parity equals the inverse of the parity before the trigger edge
    if (tb_par == want_par) tick();
    ifc.cpu_address = 16'h4014;
    ifc.cpu_out = 8'h02;
    ifc.cpu_we = 1'b1;
    ce = 1'b1;
    #1;
    chk("locked_before_trig", 32'(ifc.cpu_locked), 32'd1);
    tick();
    ifc.cpu_we = 1'b0;
    ifc.cpu_address = 16'h0000;
    ifc.cpu_out = 8'h00;
    chk("active_after_trig", 32'(ifc.dma_active), 32'd1);
    chk("locked_after_trig", 32'(ifc.cpu_locked), 32'd0);
    k = 0; nce = 0; nwr = 0; nrd = 0; dummies = 0; gate_err = 0; addr_err = 0; clocks = 0;
    while (ifc.dma_active && clocks < 20000) begin
      ce = ((k % period) == 0);
      k++;
      if (inject && nce == 10) begin
        ifc.cpu_address = 16'h4014;
        ifc.cpu_out = 8'h77;
        ifc.cpu_we = 1'b1;
      end else begin
        ifc.cpu_address = 16'h0000;
        ifc.cpu_we = 1'b0;
      end
      #1;
      if (ce) begin
        nce++;
        if (ifc.bus_we) begin
          if (nwr < 256) wdata[nwr] = ifc.bus_out;
          if (ifc.bus_address != 16'h2004) addr_err++;
          nwr++;
        end else if (ifc.bus_rd) begin
          if (ifc.bus_address != {8'h02, 8'(nrd)}) addr_err++;
          nrd++;
        end else begin
          dummies++;
        end
      end
      snap = {ifc.bus_rd, ifc.bus_we, ifc.bus_address, ifc.bus_out};
      was_ce = ce;
      tick();
      clocks++;
      if (!was_ce && snap != {ifc.bus_rd, ifc.bus_we, ifc.bus_address, ifc.bus_out}) gate_err++;
      if (abort_at != 0 && nwr == abort_at) begin
        reset = 1'b1;
        ce = 1'b0;
        tick();
        reset = 1'b0;
        break;
      end
    end
    ifc.cpu_we = 1'b0;
    chk("xfer_timeout", 32'(clocks < 20000), 32'd1);
    chk("addr_errors", 32'(addr_err), 32'd0);
    chk("gate_errors", 32'(gate_err), 32'd0);
    for (int i = 0; i < 256; i++) begin
      if (i < nwr) chk("wr_data", 32'(wdata[i]), 32'(8'(i) ^ 8'h5A));
    end
    if (abort_at != 0) begin
      chk("abort_nwr", 32'(nwr), 32'(abort_at));
      chk("abort_active", 32'(ifc.dma_active), 32'd0);
      chk("abort_we", 32'(ifc.bus_we), 32'd0);
      chk("abort_rd", 32'(ifc.bus_rd), 32'd0);
      chk("abort_addr", 32'(ifc.bus_address), 32'h0000);
      chk("abort_out", 32'(ifc.bus_out), 32'h00);
      ce = 1'b1;
      #1;
      chk("abort_locked_ce1", 32'(ifc.cpu_locked), 32'd1);
      wr_after = 0;
      for (int i = 0; i < 600; i++) begin
        tick();
        if (ifc.bus_we || ifc.dma_active) wr_after++;
      end
      chk("abort_no_more_writes", 32'(wr_after), 32'd0);
    end else begin
      chk("ce_cycles", 32'(nce), want_par ? 32'd513 : 32'd514);
      chk("num_writes", 32'(nwr), 32'd256);
      chk("num_reads", 32'(nrd), 32'd256);
      chk("dummy_cycles", 32'(dummies), want_par ? 32'd1 : 32'd2);
      ce = 1'b1;
      #1;
      chk("locked_after_xfer", 32'(ifc.cpu_locked), 32'd1);
      chk("idle_addr", 32'(ifc.bus_address), 32'h0000);
      chk("idle_bus_out", 32'(ifc.bus_out), 32'hA5);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    tb_par = 1'b0;
    reset = 1'b1;
    ce = 1'b0;
    ifc.cpu_address = 16'h0000;
    ifc.cpu_out = 8'h00;
    ifc.cpu_we = 1'b0;

    // Reset held three clocks with ce toggling
    for (int i = 0; i < 3; i++) begin
      ce = ~ce;
      tick();
      ce = ~ce;
      #1;
      chk("rst_active", 32'(ifc.dma_active), 32'd0);
      chk("rst_rd", 32'(ifc.bus_rd), 32'd0);
      chk("rst_we", 32'(ifc.bus_we), 32'd0);
      chk("rst_locked", 32'(ifc.cpu_locked), 32'(ce));
      chk("rst_addr", 32'(ifc.bus_address), 32'h0000);
      chk("rst_out", 32'(ifc.bus_out), 32'h00);
    end
    reset = 1'b0;

    // Address decode: only a write to $4014 starts a transfer
    ce = 1'b1;
    ifc.cpu_out = 8'h02;
    ifc.cpu_address = 16'h4015; ifc.cpu_we = 1'b1; tick();
    chk("dec_4015", 32'(ifc.dma_active), 32'd0);
    ifc.cpu_address = 16'h2014; ifc.cpu_we = 1'b1; tick();
    chk("dec_2014", 32'(ifc.dma_active), 32'd0);
    ifc.cpu_address = 16'h4014; ifc.cpu_we = 1'b0; tick();
    chk("dec_rd_4014", 32'(ifc.dma_active), 32'd0);
    ifc.cpu_address = 16'h4014; ifc.cpu_we = 1'b1; ce = 1'b0; tick();
    chk("dec_ce0_4014", 32'(ifc.dma_active), 32'd0);
    ifc.cpu_we = 1'b0;

    run_xfer(1, 1'b0, 0, 1'b0);
    run_xfer(1, 1'b1, 0, 1'b1);
    run_xfer(3, 1'b0, 0, 1'b0);
    run_xfer(12, 1'b1, 0, 1'b0);
    run_xfer(1, 1'b0, 100, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 SHALL have port: clock  in  1  system clock; all state on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: ce  in  1  CPU-cycle enable strobe; all state advances only when ce=1.
REQ-004 SHALL have port: cpu_address  in  16  CPU bus address, snooped.
REQ-005 SHALL have port: cpu_out  in  8  CPU write data, snooped.
REQ-006 SHALL have port: cpu_we  in  1  CPU write strobe, snooped.
REQ-007 SHALL have port: cpu_locked  out  1  run-enable to the CPU core.
REQ-008 SHALL have port: dma_active  out  1  DMA owns the bus; also the system bus-mux select.
REQ-009 SHALL have port: bus_address  out  16  DMA bus address.
REQ-010 SHALL have port: bus_in  in  8  bus read data.
REQ-011 SHALL have port: bus_out  out  8  DMA write data.
REQ-012 SHALL have port: bus_rd  out  1  DMA read strobe.
REQ-013 SHALL have port: bus_we  out  1  DMA write strobe.
REQ-014 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-015 SHALL implement states IDLE, HALT, ALIGN, READ and WRITE in a single state register.
REQ-016 SHALL keep 1-bit parity par, toggled on every ce=1 edge, in all states.
REQ-017 SHALL, in IDLE with ce=1, cpu_we=1 and cpu_address=16'h4014, latch page<=cpu_out, clear idx to 0 and enter HALT.
REQ-018 SHALL ignore a write to any address other than 16'h4014, including 16'h4015 and 16'h2014.
REQ-019 SHALL ignore a $4014 write while dma_active=1.
REQ-020 SHALL hold all state and outputs unchanged while ce=0.
REQ-021 SHALL treat HALT as one dummy cycle with no bus strobes.
REQ-022 SHALL, on leaving HALT, enter READ if par=1 during HALT, otherwise enter ALIGN.
REQ-023 SHALL treat ALIGN as one dummy cycle with no bus strobes, then enter READ; READ cycles therefore always fall on par=0.
REQ-024 SHALL, in READ: drive bus_address={page,idx} and bus_rd=1; on the ce=1 edge latch data<=bus_in; then enter WRITE.
REQ-025 SHALL, in WRITE: drive bus_address=16'h2004, bus_out=data and bus_we=1; on the ce=1 edge increment idx (8-bit).
REQ-026 SHALL, from WRITE, enter IDLE if idx was 8'hFF before the increment, otherwise enter READ.
REQ-027 SHALL leave idx wrapped to 0 at the end of a transfer, with no carry into page.
REQ-028 SHALL take 513 ce cycles per transfer (HALT + 256x{READ,WRITE}) when par=1 in HALT, and 514 when par=0 in HALT.
REQ-029 SHALL decode dma_active=1 in every state except IDLE, directly from the state register.
REQ-030 SHALL decode bus_rd and bus_we from the state register only; both SHALL be 0 in IDLE, HALT and ALIGN.
REQ-031 SHALL drive cpu_locked = ce AND NOT dma_active, as the only combinational path from an input to an output.
REQ-032 SHALL make cpu_locked fall on the clock after the triggering write and rise on the clock after the final WRITE.
REQ-033 SHALL drive bus_address=16'h0000 and bus_out=data when IDLE.

Reset
REQ-034 SHALL, on reset=1 at a clock edge regardless of ce, set state=IDLE, page=0, idx=0, data=0 and par=0.
REQ-035 SHALL hold outputs dma_active=0, bus_rd=0, bus_we=0, bus_address=16'h0000 and bus_out=8'h00 while reset=1.
REQ-036 SHALL, on reset mid-transfer, abort with no further bus strobes; cpu_locked follows ce from the next clock.

Verification
REQ-037 SHALL verify reset: reset held 3 clocks with ce toggling -> dma_active=0, bus_rd=0, bus_we=0, cpu_locked==ce.
REQ-038 SHALL verify a par=0 transfer: model RAM $0200+i=i^8'h5A, CPU writes 8'h02 to $4014 with par=0 in HALT -> 514 ce cycles with dma_active=1; 256 writes to $2004 carrying 8'h5A,8'h5B,...,8'hA5 in order.
REQ-039 SHALL verify a par=1 transfer: same transfer with par=1 in HALT -> exactly 513 ce cycles and no ALIGN visited.
REQ-040 SHALL verify decode: writes to $4015 and $2014, and a read of $4014 -> dma_active stays 0.
REQ-041 SHALL verify reset abort: reset asserted after the 100th WRITE -> next clock IDLE, bus_we=0, and no $2004 write after the 100th.
REQ-042 SHALL verify ce gating: ce pulsed 1-in-3, then 1-in-12 -> same ce-cycle count, same data sequence, no strobe changes while ce=0.
